time_display_scanner: RTL and testbench

Multiplexed six-digit seven-segment driver that consumes the packed-BCD hh/mm/ss time produced by the 24-hour clock counters and scans it onto a common-anode display. Time is captured into shadow registers on a `load` strobe so the display never tears mid-frame. Each captured field is range-checked, and invalid fields are blanked and flagged. It sits between the clock core and the board pins.

---
 rtl/time_display_scanner.sv | 163 ++++++++++++++++
 tb/tb_time_display_scanner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_scanner.sv
// Six-digit multiplexed seven-segment scanner for packed-BCD hh:mm:ss.
// Ports: clk, reset (async, active-high), load, hh/mm/ss in; an, seg, dp, err, frame out.
// Define DISPLAY_BLINK_EN to blink the separators at the seconds rate.
module time_display_scanner #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       err,
  output logic       frame
);

  localparam int PCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);

  logic [PCW-1:0] pc_q, pc_d;
  logic [2:0]     di_q, di_d;
  logic           wrap_q, wrap_d;
  logic [7:0]     sh_h_q, sh_h_d;
  logic [7:0]     sh_m_q, sh_m_d;
  logic [7:0]     sh_s_q, sh_s_d;
  logic           vh_q, vh_d;
  logic           vm_q, vm_d;
  logic           vs_q, vs_d;
  logic           err_q, err_d;
  logic [5:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic           frame_q, frame_d;

  logic [3:0] nib;
  logic       nib_ok;
  logic       sep;

  function automatic logic hh_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= 8'h23);
  endfunction

  function automatic logic ms_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    pc_d   = pc_q + 1'b1;
    di_d   = di_q;
    wrap_d = 1'b0;
    if (pc_q == PC_LAST) begin
      pc_d = '0;
      if (di_q == 3'd5) begin
        di_d   = 3'd0;
        wrap_d = 1'b1;
      end else begin
        di_d = di_q + 3'd1;
      end
    end

    sh_h_d = sh_h_q;
    sh_m_d = sh_m_q;
    sh_s_d = sh_s_q;
    vh_d   = vh_q;
    vm_d   = vm_q;
    vs_d   = vs_q;
    err_d  = err_q;
    if (load) begin
      sh_h_d = hh;
      sh_m_d = mm;
      sh_s_d = ss;
      vh_d   = hh_ok(hh);
      vm_d   = ms_ok(mm);
      vs_d   = ms_ok(ss);
      err_d  = ~(hh_ok(hh) & ms_ok(mm) & ms_ok(ss));
    end

    nib    = 4'hF;
    nib_ok = 1'b0;
    case (di_q)
      3'd0: begin nib = sh_h_q[7:4]; nib_ok = vh_q; end
      3'd1: begin nib = sh_h_q[3:0]; nib_ok = vh_q; end
      3'd2: begin nib = sh_m_q[7:4]; nib_ok = vm_q; end
      3'd3: begin nib = sh_m_q[3:0]; nib_ok = vm_q; end
      3'd4: begin nib = sh_s_q[7:4]; nib_ok = vs_q; end
      3'd5: begin nib = sh_s_q[3:0]; nib_ok = vs_q; end
      default: ;
    endcase

    an_d  = ~(6'b000001 << di_q);
    seg_d = nib_ok ? dec7(nib) : 7'h7F;
    sep   = (di_q == 3'd1) || (di_q == 3'd3);
`ifdef DISPLAY_BLINK_EN
    dp_d  = ~(sep & vs_q & ~sh_s_q[0]);
`else
    dp_d  = ~sep;
`endif
    // wrap_q marks that di just returned to 0, so this edge shows digit 0 of a new scan
    frame_d = wrap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      di_q    <= 3'd0;
      wrap_q  <= 1'b0;
      sh_h_q  <= 8'h00;
      sh_m_q  <= 8'h00;
      sh_s_q  <= 8'h00;
      vh_q    <= 1'b1;
      vm_q    <= 1'b1;
      vs_q    <= 1'b1;
      err_q   <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      di_q    <= di_d;
      wrap_q  <= wrap_d;
      sh_h_q  <= sh_h_d;
      sh_m_q  <= sh_m_d;
      sh_s_q  <= sh_s_d;
      vh_q    <= vh_d;
      vm_q    <= vm_d;
      vs_q    <= vs_d;
      err_q   <= err_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign err   = err_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner (SCAN_DIV=4).
// Random and directed loads compared against a cycle-count display model.
module tb_time_display_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] hh, mm, ss;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp, err, frame;

  int total = 0;
  int bad = 0;

  time_display_scanner #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .load(load),
    .hh(hh), .mm(mm), .ss(ss),
    .an(an), .seg(seg), .dp(dp), .err(err), .frame(frame)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         k;
  logic [7:0] m_f [3];
  bit         m_ok [3];
  logic [5:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp, e_err, e_frame;

  function automatic bit field_ok(input logic [7:0] v, input int lim);
    int t, u;
    t = v[7:4];
    u = v[3:0];
    return (t <= 9) && (u <= 9) && (t * 10 + u <= lim);
  endfunction

  function automatic logic [7:0] rnd_field(input int lim);
    int n;
    logic [7:0] r;
    if ($urandom_range(0, 3) == 0) begin
      r = 8'($urandom_range(0, 255));
    end else begin
      n = $urandom_range(0, lim);
      r = {4'(n / 10), 4'(n % 10)};
    end
    return r;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 3; i++) begin
      m_f[i]  = 8'h00;
      m_ok[i] = 1'b1;
    end
  endtask

  // One clock edge; expectations come from edges-since-release and model shadows.
  task automatic step(input bit ld, input logic [7:0] h,
                      input logic [7:0] m, input logic [7:0] s);
    int d, f;
    logic [7:0] v;
    logic [3:0] nb;
    load = ld; hh = h; mm = m; ss = s;
    @(posedge clk);
    #1;
    k++;
    d = ((k - 1) / 4) % 6;
    f = d / 2;
    v = m_f[f];
    nb = (d % 2 == 1) ? v[3:0] : v[7:4];
    e_an = 6'h3F & ~(6'd1 << d);
    e_seg = m_ok[f] ? segtab[nb] : 7'h7F;
    e_frame = (k > 1) && ((k - 1) % 24 == 0);
`ifdef DISPLAY_BLINK_EN
    e_dp = !((d == 1 || d == 3) && m_ok[2] && (m_f[2] % 2 == 0));
`else
    e_dp = !(d == 1 || d == 3);
`endif
    if (ld) begin
      m_f[0] = h; m_f[1] = m; m_f[2] = s;
      m_ok[0] = field_ok(h, 23);
      m_ok[1] = field_ok(m, 59);
      m_ok[2] = field_ok(s, 59);
    end
    e_err = !(m_ok[0] && m_ok[1] && m_ok[2]);
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if ({an, seg, dp, err, frame} !== {6'h3F, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got an=%h seg=%h dp=%b err=%b frame=%b",
               an, seg, dp, err, frame);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    step(0, 8'h00, 8'h00, 8'h00);
    total++;
    if (an !== 6'b111110 || seg !== 7'h40 || frame !== 1'b0) begin
      bad++;
      $display("FAIL first_edge: got an=%b seg=%h frame=%b want 111110 40 0",
               an, seg, frame);
    end
  endtask

  task automatic test_normal_scan();
    int frames;
    frames = 0;
    step(1, 8'h23, 8'h58, 8'h45);
    for (int i = 0; i < 48; i++) begin
      step(0, 8'h00, 8'h00, 8'h00);
      frames += int'(frame);
      total++;
      if ({an, seg, dp, err, frame} !== {e_an, e_seg, e_dp, e_err, e_frame}) begin
        bad++;
        $display("FAIL normal_scan k=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                 k, an, seg, dp, err, frame, e_an, e_seg, e_dp, e_err, e_frame);
      end
    end
    total++;
    if (frames != 2) begin
      bad++;
      $display("FAIL frame_count: got %0d want 2", frames);
    end
  endtask

  task automatic test_invalid();
    step(1, 8'h24, 8'h00, 8'h3A);
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL invalid_err: got %b want 1", err);
    end
    for (int i = 0; i < 25; i++) begin
      step(0, 8'h00, 8'h00, 8'h00);
      total++;
      if ({an, seg, dp, err, frame} !== {e_an, e_seg, e_dp, e_err, e_frame}) begin
        bad++;
        $display("FAIL invalid_scan k=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                 k, an, seg, dp, err, frame, e_an, e_seg, e_dp, e_err, e_frame);
      end
      if (an == 6'b111011) begin
        total++;
        if (seg !== 7'h40) begin
          bad++;
          $display("FAIL invalid_mm_digit: got %h want 40", seg);
        end
      end
    end
    step(1, 8'h12, 8'h34, 8'h56);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL invalid_clear: got %b want 0", err);
    end
  endtask

  task automatic test_collision();
    step(1, 8'h23, 8'h58, 8'h45);
    while ((k + 1) % 24 != 12) step(0, 8'h00, 8'h00, 8'h00);
    step(1, 8'h23, 8'h59, 8'h45);
    step(0, 8'h00, 8'h00, 8'h00);
    total++;
    if (an !== 6'b110111 || seg !== 7'h10 || seg !== e_seg) begin
      bad++;
      $display("FAIL collision: got an=%b seg=%h want 110111 10", an, seg);
    end
  endtask

  task automatic test_random();
    bit ld;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      step(ld, rnd_field(23), rnd_field(59), rnd_field(59));
      total++;
      if ({an, seg, dp, err, frame} !== {e_an, e_seg, e_dp, e_err, e_frame}) begin
        bad++;
        $display("FAIL random k=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                 k, an, seg, dp, err, frame, e_an, e_seg, e_dp, e_err, e_frame);
      end
    end
  endtask

  task automatic test_reset_midscan();
    int n;
    n = $urandom_range(5, 17);
    step(1, 8'h21, 8'h07, 8'h33);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 8'h00);
    test_reset();
    for (int i = 0; i < 30; i++) begin
      step(0, 8'h00, 8'h00, 8'h00);
      total++;
      if ({an, seg, dp, err, frame} !== {e_an, e_seg, e_dp, e_err, e_frame}) begin
        bad++;
        $display("FAIL after_reset k=%0d: got %h/%h/%b/%b/%b want %h/%h/%b/%b/%b",
                 k, an, seg, dp, err, frame, e_an, e_seg, e_dp, e_err, e_frame);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    load = 1'b0;
    hh = 8'h00; mm = 8'h00; ss = 8'h00;
    model_reset();
    #2;
    test_reset();
    test_normal_scan();
    test_invalid();
    test_collision();
    test_random();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
